// File: rtl/mnist_core_arbiter_if.sv
// Bus bundle between the image sources, the shared mnist_model core and the arbiter.
// The master side is the arbiter; the slave side is the surrounding environment.
interface mnist_core_arbiter_if #(
  parameter int NUM_REQ  = 2,
  parameter int IMG_BITS = 784
);
  localparam int ID_W = $clog2(NUM_REQ);

  // Requester side
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*IMG_BITS-1:0] img_flat;
  logic [NUM_REQ-1:0]          done;
  logic [3:0]                  resp_digit;
  logic                        resp_err;
  logic                        busy;
  logic [ID_W-1:0]             grant_id;

  // Inference core side
  logic [IMG_BITS-1:0]         core_image;
  logic                        core_start;
  logic                        core_valid;
  logic [3:0]                  core_digit;

  modport master (
    input  req, img_flat, core_valid, core_digit,
    output done, resp_digit, resp_err, busy, grant_id, core_image, core_start
  );

  modport slave (
    output req, img_flat, core_valid, core_digit,
    input  done, resp_digit, resp_err, busy, grant_id, core_image, core_start
  );
endinterface

// File: rtl/mnist_core_arbiter.sv
// Round-robin arbiter sharing one mnist_model inference core between NUM_REQ image
// sources. Latches the winning image, pulses the core start, waits for the result
// (or a timeout) and returns a one-cycle done/digit response to the winner.
module mnist_core_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int IMG_BITS       = 784,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mnist_core_arbiter_if.master  bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state_q,  state_n;
  logic [ID_W-1:0]     ptr_q,    ptr_n;
  logic [CNT_W-1:0]    cnt_q,    cnt_n;
  logic [NUM_REQ-1:0]  done_q,   done_n;
  logic [3:0]          digit_q,  digit_n;
  logic                err_q,    err_n;
  logic                busy_q,   busy_n;
  logic [ID_W-1:0]     grant_q,  grant_n;
  logic [IMG_BITS-1:0] image_q,  image_n;
  logic                start_q,  start_n;

  logic                found;
  logic [ID_W-1:0]     winner;
  int                  idx;

  // Next-state and next-output logic; every output is taken from a register below
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    done_n  = done_q;
    digit_n = digit_q;
    err_n   = err_q;
    busy_n  = busy_q;
    grant_n = grant_q;
    image_n = image_q;
    start_n = start_q;
    found   = 1'b0;
    winner  = '0;
    idx     = 0;

    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_n = winner;
          image_n = bus.img_flat[winner*IMG_BITS +: IMG_BITS];
          start_n = 1'b1;
          busy_n  = 1'b1;
          state_n = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        start_n = 1'b0;
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.core_valid) begin
          digit_n          = bus.core_digit;
          err_n            = (bus.core_digit > 4'd9);
          done_n           = '0;
          done_n[grant_q]  = bus.req[grant_q];
          state_n          = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          digit_n          = 4'hF;
          err_n            = 1'b1;
          done_n           = '0;
          done_n[grant_q]  = bus.req[grant_q];
          state_n          = S_RESP;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        done_n  = '0;
        err_n   = 1'b0;
        busy_n  = 1'b0;
        ptr_n   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(grant_q + 1'b1);
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        ptr_n   = '0;
        cnt_n   = '0;
        done_n  = '0;
        digit_n = '0;
        err_n   = 1'b0;
        busy_n  = 1'b0;
        grant_n = '0;
        image_n = '0;
        start_n = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      digit_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      image_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      done_q  <= done_n;
      digit_q <= digit_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
      grant_q <= grant_n;
      image_q <= image_n;
      start_q <= start_n;
    end
  end

  assign bus.done       = done_q;
  assign bus.resp_digit = digit_q;
  assign bus.resp_err   = err_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_q;
  assign bus.core_image = image_q;
  assign bus.core_start = start_q;

endmodule
